uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, bit-period and frame-length helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned calc_t_baud(input int unsigned f_mhz, input int unsigned baud);
    return (f_mhz * 32'd1000000) / baud;
  endfunction

  function automatic int unsigned frame_len(input int unsigned n_bits);
    return n_bits + 32'd2;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period cycle counter, counts 0..T_BAUD-1 and wraps; tick on the last cycle.
module uart_baud_cnt #(
  parameter int unsigned T_BAUD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (T_BAUD > 1) ? $clog2(T_BAUD) : 1;
  localparam logic [W-1:0] LAST = W'(T_BAUD - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: one-entry holding register, 8N1-style framing, back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int n         = 8,
  parameter int f_MHz     = 50,
  parameter int baud_rate = 9600
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         send_req,
  input  logic [n-1:0] d_in,
  output logic         ready,
  output logic         TX,
  output logic         busy,
  output logic         send_done
);

  localparam int unsigned T_BAUD = calc_t_baud(f_MHz, baud_rate);
  localparam int BW = $clog2(n + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(n - 1);

  generate
    if (T_BAUD < 2) begin : g_bad_baud
      $error("uart_tx: T_baud must be >= 2");
    end
  endgenerate

  uart_state_e r_state, w_next;
  logic [n-1:0]  r_hold, r_shift;
  logic          r_hold_full, r_tx;
  logic [BW-1:0] r_bit;
  logic          w_tick, w_load, w_accept;

  uart_baud_cnt #(.T_BAUD(T_BAUD)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (r_state == IDLE),
    .en   (1'b1),
    .tick (w_tick)
  );

  assign w_accept = send_req && !r_hold_full;

  // w_load marks entry to START: shifter loads and the holding register drains on that edge
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: if (r_hold_full) begin
        w_next = START;
        w_load = 1'b1;
      end
      START: if (w_tick) w_next = DATA;
      DATA:  if (w_tick && r_bit == LAST_BIT) w_next = STOP;
      STOP: if (w_tick) begin
        if (r_hold_full) begin
          w_next = START;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= d_in;
      r_hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else if (w_load) begin
      r_shift <= r_hold;
      r_bit   <= '0;
      r_tx    <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        START: begin
          r_tx    <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_bit   <= '0;
        end
        DATA: begin
          if (r_bit == LAST_BIT) begin
            r_tx <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
          end
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign ready     = !r_hold_full;
  assign TX        = r_tx;
  assign busy      = (r_state != IDLE);
  assign send_done = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed/randomized self-checking bench for uart_tx with a frame-level reference model.
module tb_uart_tx;

  localparam int N  = 8;
  localparam int T  = 4;
  localparam int FC = (N + 2) * T;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_req = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       ready, TX, busy, send_done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] bytes [4];

  uart_tx #(.n(N), .f_MHz(1), .baud_rate(250000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .send_req (send_req),
    .d_in     (d_in),
    .ready    (ready),
    .TX       (TX),
    .busy     (busy),
    .send_done(send_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // line level of bit-period k of the frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= N) return logic'((b >> (k - 1)) & 8'h01);
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b, output int rejected);
    logic rdy;
    bit   acc;
    rejected = 0;
    acc = 0;
    send_req = 1'b1;
    d_in = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rdy = ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1;
        break;
      end
      rejected++;
    end
    #1;
    send_req = 1'b0;
    d_in = 8'($urandom);
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_stream(input logic [7:0] b [4], input int nb);
    for (int c = 0; c < nb * FC; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tx_f%0d_c%0d", c / FC, c % FC), TX, frame_bit(b[c / FC], (c % FC) / T));
      chk($sformatf("busy_c%0d", c), busy, 1);
      chk($sformatf("done_c%0d", c), send_done, (c % FC) == FC - 1);
    end
    @(posedge clk);
    #1;
    chk("idle_tx", TX, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", send_done, 0);
  endtask

  task automatic rx_bytes(input logic [7:0] exp [4], input int nb);
    logic [7:0] got;
    int  got_n;
    bit  seen;
    got_n = 0;
    for (int k = 0; k < nb; k++) begin
      seen = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (TX === 1'b0) begin
          seen = 1;
          break;
        end
      end
      if (!seen) break;
      repeat (2) @(negedge clk);
      chk("rx_start", TX, 0);
      for (int j = 0; j < N; j++) begin
        repeat (T) @(negedge clk);
        got[j] = TX;
      end
      repeat (T) @(negedge clk);
      chk("rx_stop", TX, 1);
      chk($sformatf("rx_byte%0d", k), got, exp[k]);
      got_n++;
    end
    chk("rx_count", got_n, nb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2;

    #12;
    chk("rst_tx", TX, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", send_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single byte
    bytes[0] = 8'hA5;
    push(8'hA5, r);
    chk("s1_rej", r, 0);
    check_stream(bytes, 1);

    // back-to-back, second request lands on the drain edge and must slip one edge
    bytes[0] = 8'h00; bytes[1] = 8'hFF;
    push(8'h00, r);
    fork
      check_stream(bytes, 2);
      begin
        push(8'hFF, r2);
        chk("b2b_rej", r2, 1);
      end
    join

    // back-pressure: 0x3C waits until 0x22 is drained at the end of the first frame
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h3C;
    push(8'h11, r);
    fork
      check_stream(bytes, 3);
      begin
        int ra, rb;
        push(8'h22, ra);
        chk("bp_rej_22", ra, 1);
        push(8'h3C, rb);
        chk("bp_rej_3c", rb, FC - 1);
      end
    join

    // reset during data bit 3
    push(8'h52, r);
    repeat (1 + 4 * T + 1) @(posedge clk);
    #1;
    chk("mid_tx_bit3", TX, 0);
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", TX, 1);
    chk("arst_ready", ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", send_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", ready, 1);
    chk("post_rst_tx", TX, 1);
    bytes[0] = 8'h55;
    push(8'h55, r);
    check_stream(bytes, 1);

    // random back-to-back bytes
    for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
    push(bytes[0], r);
    fork
      check_stream(bytes, 3);
      begin
        int rr;
        push(bytes[1], rr);
        push(bytes[2], rr);
      end
    join

    // loopback through a behavioural receiver
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81; bytes[3] = 8'h7E;
    fork
      rx_bytes(bytes, 4);
      begin
        int rl;
        for (int i = 0; i < 4; i++) push(bytes[i], rl);
      end
    join
    repeat (2 * T) @(posedge clk);
    #1;
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
